// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter.
package fifo_rd_arb_pkg;

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_BURST_LEN = 4;
   localparam int MAX_IDX_W     = 5;
   localparam int MAX_REQ       = 32;

   function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
      return 32'd1 << idx;
   endfunction

   function automatic logic [MAX_IDX_W-1:0] wrap_inc(input logic [MAX_IDX_W-1:0] idx,
                                                     input logic [MAX_IDX_W-1:0] last);
      return (idx == last) ? 5'd0 : idx + 5'd1;
   endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, modulo NUM_REQ.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);

   logic [IDX_W-1:0] cand;

   // Scan from farthest to nearest so the candidate closest to ptr wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand  = IDX_W'((int'(ptr) + k) % NUM_REQ);
         found = found | req[cand];
         idx   = req[cand] ? cand : idx;
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing one FIFO read port between NUM_REQ consumers.
// Optional FIFO_RD_ARB_BURST_EN lets an owner pop up to BURST_LEN words per grant.
module fifo_rd_arbiter
   import fifo_rd_arb_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int IDX_W     = $clog2(NUM_REQ),
   parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
   input  logic               clk_i,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               fifo_empty_i,
   output logic               fifo_rd_en_o,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [NUM_REQ-1:0] rd_vld_o,
   output logic               busy_o
);

   state_t           state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] rr_ptr;
   logic [CNT_W-1:0] burst_cnt;

   logic             pop;
   logic             release_grant;
   logic [IDX_W-1:0] next_ptr;
   logic [IDX_W-1:0] idle_idx;
   logic             idle_found;
   logic [IDX_W-1:0] own_idx;
   logic             own_found;

   assign pop          = (state == OWN) & req_i[owner] & ~fifo_empty_i;
   assign fifo_rd_en_o = pop;
   assign busy_o       = (state == OWN);
   assign next_ptr     = IDX_W'(wrap_inc(MAX_IDX_W'(owner), MAX_IDX_W'(NUM_REQ - 1)));

`ifdef FIFO_RD_ARB_BURST_EN
   assign release_grant = pop & (burst_cnt == CNT_W'(BURST_LEN - 1));
`else
   assign release_grant = pop;
`endif

   rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_idle_pick (
      .req   (req_i),
      .ptr   (rr_ptr),
      .idx   (idle_idx),
      .found (idle_found)
   );

   // Re-pick starts after the owner, so the owner is considered last.
   rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_own_pick (
      .req   (req_i),
      .ptr   (next_ptr),
      .idx   (own_idx),
      .found (own_found)
   );

   // Arbitration FSM with registered grant and read-valid outputs.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
         gnt_o     <= '0;
         rd_vld_o  <= '0;
      end else begin
         rd_vld_o <= pop ? gnt_o : '0;
         case (state)
            IDLE: begin
               if (idle_found) begin
                  gnt_o     <= NUM_REQ'(onehot(MAX_IDX_W'(idle_idx)));
                  owner     <= idle_idx;
                  burst_cnt <= '0;
                  state     <= OWN;
               end else begin
                  gnt_o <= '0;
               end
            end
            OWN: begin
               if (!req_i[owner]) begin
                  rr_ptr <= next_ptr;
                  gnt_o  <= '0;
                  state  <= IDLE;
               end else if (release_grant) begin
                  rr_ptr <= next_ptr;
                  if (own_found) begin
                     gnt_o     <= NUM_REQ'(onehot(MAX_IDX_W'(own_idx)));
                     owner     <= own_idx;
                     burst_cnt <= '0;
                  end else begin
                     gnt_o <= '0;
                     state <= IDLE;
                  end
               end else if (pop) begin
                  burst_cnt <= burst_cnt + CNT_W'(1'b1);
               end else begin
                  burst_cnt <= burst_cnt;
               end
            end
            default: begin
               gnt_o <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter; burst scenario runs when FIFO_RD_ARB_BURST_EN is defined.
module tb_fifo_rd_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic       force_empty = 1'b0;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [3:0] gnt;
   logic [3:0] rd_vld;
   logic       busy;
   int         load_cnt = 0;
   int         pop_cnt = 0;
   int         vec = 0;
   int         miss = 0;

   fifo_rd_arbiter dut (
      .clk_i        (clk),
      .rst_n        (rst_n),
      .req_i        (req),
      .fifo_empty_i (fifo_empty),
      .fifo_rd_en_o (fifo_rd_en),
      .gnt_o        (gnt),
      .rd_vld_o     (rd_vld),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   // FIFO occupancy model: words loaded by the stimulus minus words popped.
   assign fifo_empty = force_empty | (pop_cnt == load_cnt);
   always @(posedge clk) if (fifo_rd_en) pop_cnt <= pop_cnt + 1;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input int words);
      @(negedge clk);
      rst_n = 1'b0;
      req = 4'b0000;
      force_empty = 1'b0;
      @(negedge clk);
      load_cnt = pop_cnt + words;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [3:0] exp_vld;
      @(negedge clk);
      vec++;
      if ({gnt, rd_vld, fifo_rd_en, busy} !== 10'b0) begin
         miss++;
         $display("FAIL reset_state gnt=%b vld=%b en=%b busy=%b, want all 0", gnt, rd_vld, fifo_rd_en, busy);
      end
      do_reset(8);
      req = 4'b1111;
      tick(); tick(); tick();
      vec++;
      if (rd_vld !== 4'b0010) begin
         miss++;
         $display("FAIL pre_reset_vld got %b want 0010", rd_vld);
      end
      rst_n = 1'b0;
      #1;
      vec++;
      if ({gnt, rd_vld, fifo_rd_en, busy} !== 10'b0) begin
         miss++;
         $display("FAIL midburst_reset gnt=%b vld=%b en=%b busy=%b, want all 0", gnt, rd_vld, fifo_rd_en, busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      exp_vld = 4'b0001;
      vec++;
      if (gnt !== exp_vld) begin
         miss++;
         $display("FAIL rr_ptr_reset gnt got %b want %b", gnt, exp_vld);
      end
      do_reset(4);
      req = 4'b0100;
      tick();
      vec++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
         miss++;
         $display("FAIL first_req_after_reset gnt=%b busy=%b want 0100/1", gnt, busy);
      end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_vld;
      logic       exp_en;
      do_reset(8);
      req = 4'b1111;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp_vld = (k >= 2) ? (4'b0001 << ((k - 2) % 4)) : 4'b0000;
         exp_en  = (k <= 8);
         vec++;
         if (rd_vld !== exp_vld || fifo_rd_en !== exp_en) begin
            miss++;
            $display("FAIL fairness cyc%0d vld=%b en=%b want %b/%b", k, rd_vld, fifo_rd_en, exp_vld, exp_en);
         end
      end
      req = 4'b0000;
   endtask

   task automatic test_empty();
      do_reset(6);
      force_empty = 1'b1;
      req = 4'b0100;
      for (int k = 1; k <= 5; k++) begin
         tick();
         vec++;
         if (gnt !== 4'b0100 || fifo_rd_en !== 1'b0 || rd_vld !== 4'b0000) begin
            miss++;
            $display("FAIL empty_hold cyc%0d gnt=%b en=%b vld=%b want 0100/0/0000", k, gnt, fifo_rd_en, rd_vld);
         end
      end
      force_empty = 1'b0;
      #1;
      vec++;
      if (fifo_rd_en !== 1'b1) begin
         miss++;
         $display("FAIL empty_release en got %b want 1", fifo_rd_en);
      end
      tick();
      vec++;
      if (rd_vld !== 4'b0100 || gnt !== 4'b0100) begin
         miss++;
         $display("FAIL empty_first_pop vld=%b gnt=%b want 0100/0100", rd_vld, gnt);
      end
      req = 4'b0000;
   endtask

   task automatic test_release();
      do_reset(6);
      req = 4'b1010;
      tick();
      vec++;
      if (gnt !== 4'b0010) begin
         miss++;
         $display("FAIL release_grant1 gnt got %b want 0010", gnt);
      end
      req = 4'b1000;
      #1;
      vec++;
      if (fifo_rd_en !== 1'b0) begin
         miss++;
         $display("FAIL release_no_pop en got %b want 0", fifo_rd_en);
      end
      tick();
      vec++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || rd_vld !== 4'b0000) begin
         miss++;
         $display("FAIL release_idle gnt=%b busy=%b vld=%b want 0000/0/0000", gnt, busy, rd_vld);
      end
      tick();
      vec++;
      if (gnt !== 4'b1000 || rd_vld !== 4'b0000) begin
         miss++;
         $display("FAIL release_regrant gnt=%b vld=%b want 1000/0000", gnt, rd_vld);
      end
      tick();
      vec++;
      if (rd_vld !== 4'b1000) begin
         miss++;
         $display("FAIL release_pop3 vld got %b want 1000", rd_vld);
      end
      req = 4'b0000;
   endtask

   task automatic test_wrap();
      logic [3:0] exp_gnt [3];
      logic [3:0] exp_vld [3];
      exp_gnt[0] = 4'b1000; exp_gnt[1] = 4'b0001; exp_gnt[2] = 4'b1000;
      exp_vld[0] = 4'b0000; exp_vld[1] = 4'b1000; exp_vld[2] = 4'b0001;
      do_reset(6);
      req = 4'b0100;
      tick();
      req = 4'b1001;
      tick();
      for (int k = 0; k < 3; k++) begin
         tick();
         vec++;
         if (gnt !== exp_gnt[k] || rd_vld !== exp_vld[k]) begin
            miss++;
            $display("FAIL wrap step%0d gnt=%b vld=%b want %b/%b", k, gnt, rd_vld, exp_gnt[k], exp_vld[k]);
         end
      end
      req = 4'b0000;
   endtask

`ifdef FIFO_RD_ARB_BURST_EN
   task automatic test_burst();
      logic [3:0] exp_vld;
      do_reset(10);
      req = 4'b0011;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k >= 2 && k <= 5)      exp_vld = 4'b0001;
         else if (k >= 6 && k <= 9) exp_vld = 4'b0010;
         else if (k >= 10 && k <= 11) exp_vld = 4'b0001;
         else                        exp_vld = 4'b0000;
         vec++;
         if (rd_vld !== exp_vld) begin
            miss++;
            $display("FAIL burst cyc%0d vld got %b want %b", k, rd_vld, exp_vld);
         end
      end
      req = 4'b0000;
   endtask
`else
   task automatic test_back_to_back();
      logic [3:0] exp_vld;
      logic       exp_en;
      do_reset(3);
      req = 4'b0001;
      for (int k = 1; k <= 5; k++) begin
         tick();
         exp_vld = (k >= 2 && k <= 4) ? 4'b0001 : 4'b0000;
         exp_en  = (k <= 3);
         vec++;
         if (rd_vld !== exp_vld || fifo_rd_en !== exp_en || gnt !== 4'b0001) begin
            miss++;
            $display("FAIL back_to_back cyc%0d vld=%b en=%b gnt=%b want %b/%b/0001", k, rd_vld, fifo_rd_en, gnt, exp_vld, exp_en);
         end
      end
      req = 4'b0000;
   endtask
`endif

   initial begin
      test_reset();
      test_fairness();
      test_empty();
      test_release();
      test_wrap();
`ifdef FIFO_RD_ARB_BURST_EN
      test_burst();
`else
      test_back_to_back();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
